// File: rtl/ecc_secded_pipe_if.sv
// Bundled encode, decode and status signals of ecc_secded_pipe.
// The slave modport is the corrector's view; master is the user's view.
interface ecc_secded_pipe_if #(
  parameter int unsigned DATA_WIDTH   = 44,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned CNT_WIDTH    = 16
);
  logic                    enc_vld_in;
  logic [DATA_WIDTH-1:0]   enc_data_in;
  logic                    enc_vld_out;
  logic [DATA_WIDTH-1:0]   enc_data_out;
  logic [PARITY_WIDTH-1:0] enc_parity_out;

  logic                    dec_in_vld;
  logic                    dec_in_rdy;
  logic [DATA_WIDTH-1:0]   dec_in_data;
  logic [PARITY_WIDTH-1:0] dec_in_parity;
  logic                    dec_in_bypass;
  logic                    dec_out_vld;
  logic                    dec_out_rdy;
  logic [DATA_WIDTH-1:0]   dec_out_data;
  logic [PARITY_WIDTH-1:0] dec_out_syndrome;
  logic                    dec_out_sbit_err;
  logic                    dec_out_dbit_err;

  logic [CNT_WIDTH-1:0]    sbit_cnt;
  logic [CNT_WIDTH-1:0]    dbit_cnt;
  logic                    cnt_clr;
  logic                    log_vld;
  logic [PARITY_WIDTH-1:0] log_syndrome;
  logic                    log_dbit;
  logic                    log_clr;

  modport slave (
    input  enc_vld_in, enc_data_in,
    output enc_vld_out, enc_data_out, enc_parity_out,
    input  dec_in_vld, dec_in_data, dec_in_parity, dec_in_bypass, dec_out_rdy,
    output dec_in_rdy, dec_out_vld, dec_out_data, dec_out_syndrome,
    output dec_out_sbit_err, dec_out_dbit_err,
    output sbit_cnt, dbit_cnt, log_vld, log_syndrome, log_dbit,
    input  cnt_clr, log_clr
  );

  modport master (
    output enc_vld_in, enc_data_in,
    input  enc_vld_out, enc_data_out, enc_parity_out,
    output dec_in_vld, dec_in_data, dec_in_parity, dec_in_bypass, dec_out_rdy,
    input  dec_in_rdy, dec_out_vld, dec_out_data, dec_out_syndrome,
    input  dec_out_sbit_err, dec_out_dbit_err,
    input  sbit_cnt, dbit_cnt, log_vld, log_syndrome, log_dbit,
    output cnt_clr, log_clr
  );
endinterface

// File: rtl/ecc_secded_pipe.sv
// Parametrised Hsiao SECDED corrector: registered encoder, 2-stage valid/ready
// decoder with backpressure, saturating error counters and a first-error log.
module ecc_secded_pipe #(
  parameter int unsigned DATA_WIDTH   = 44,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic                clk,
  input logic                rst_n,
  ecc_secded_pipe_if.slave   bus
);
  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [PARITY_WIDTH-1:0] par_t;
  typedef logic [CNT_WIDTH-1:0]    cnt_t;
  typedef logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] cols_t;

  // Data bit i sits at the i-th non-power-of-two Hamming position >= 3; the MSB
  // makes every column odd weight.
  function automatic cols_t gen_cols();
    cols_t       c;
    logic [31:0] pos;
    c   = '0;
    pos = 32'd3;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      while ((pos & (pos - 32'd1)) == 32'd0) pos = pos + 32'd1;
      for (int j = 0; j < int'(PARITY_WIDTH) - 1; j++) c[i][j] = pos[j];
      c[i][PARITY_WIDTH-1] = ~^pos[PARITY_WIDTH-2:0];
      pos = pos + 32'd1;
    end
    return c;
  endfunction

  localparam cols_t Cols = gen_cols();

  function automatic par_t encode(data_t d);
    par_t p;
    p = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (d[i]) p = p ^ Cols[i];
    end
    return p;
  endfunction

  // Encode path
  logic  enc_vld_q;
  data_t enc_data_q;
  par_t  enc_par_q;

  // Decode pipeline
  logic  s1_vld_q, s1_byp_q;
  data_t s1_data_q;
  par_t  s1_syn_q;
  logic  s2_vld_q, s2_sbit_q, s2_dbit_q;
  data_t s2_data_q;
  par_t  s2_syn_q;

  logic  s2_load, in_rdy, out_hs;
  data_t corr_data;
  logic  corr_sbit, corr_dbit, col_hit;

  // Status
  cnt_t sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic log_vld_q, log_vld_d, log_dbit_q, log_dbit_d;
  par_t log_syn_q, log_syn_d;

  assign s2_load = !s2_vld_q || bus.dec_out_rdy;
  assign in_rdy  = !s1_vld_q || s2_load;
  assign out_hs  = s2_vld_q && bus.dec_out_rdy;

  always_comb begin
    corr_data = s1_data_q;
    corr_sbit = 1'b0;
    corr_dbit = 1'b0;
    col_hit   = 1'b0;
    if (!s1_byp_q && (s1_syn_q != '0)) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        if (s1_syn_q == Cols[i]) begin
          corr_data[i] = ~s1_data_q[i];
          col_hit      = 1'b1;
        end
      end
      if (col_hit || $onehot(s1_syn_q)) corr_sbit = 1'b1;
      else                              corr_dbit = 1'b1;
    end
  end

  always_comb begin
    sbit_cnt_d = sbit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    if (bus.cnt_clr) begin
      sbit_cnt_d = (out_hs && s2_sbit_q) ? cnt_t'(1) : '0;
      dbit_cnt_d = (out_hs && s2_dbit_q) ? cnt_t'(1) : '0;
    end else begin
      if (out_hs && s2_sbit_q && (sbit_cnt_q != '1)) sbit_cnt_d = sbit_cnt_q + cnt_t'(1);
      if (out_hs && s2_dbit_q && (dbit_cnt_q != '1)) dbit_cnt_d = dbit_cnt_q + cnt_t'(1);
    end
  end

  // A clear coinciding with a new error re-arms and captures in one step.
  always_comb begin
    log_vld_d  = log_vld_q;
    log_syn_d  = log_syn_q;
    log_dbit_d = log_dbit_q;
    if (bus.log_clr || !log_vld_q) begin
      if (out_hs && (s2_sbit_q || s2_dbit_q)) begin
        log_vld_d  = 1'b1;
        log_syn_d  = s2_syn_q;
        log_dbit_d = s2_dbit_q;
      end else if (bus.log_clr) begin
        log_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_vld_q  <= 1'b0;
      enc_data_q <= '0;
      enc_par_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_sbit_q  <= 1'b0;
      s2_dbit_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      sbit_cnt_q <= '0;
      dbit_cnt_q <= '0;
      log_vld_q  <= 1'b0;
      log_syn_q  <= '0;
      log_dbit_q <= 1'b0;
    end else begin
      enc_vld_q <= bus.enc_vld_in;
      if (bus.enc_vld_in) begin
        enc_data_q <= bus.enc_data_in;
        enc_par_q  <= encode(bus.enc_data_in);
      end
      if (in_rdy) begin
        s1_vld_q <= bus.dec_in_vld;
        if (bus.dec_in_vld) begin
          s1_data_q <= bus.dec_in_data;
          s1_byp_q  <= bus.dec_in_bypass;
          s1_syn_q  <= bus.dec_in_parity ^ encode(bus.dec_in_data);
        end
      end
      if (s2_load) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= corr_data;
          s2_syn_q  <= s1_syn_q;
          s2_sbit_q <= corr_sbit;
          s2_dbit_q <= corr_dbit;
        end
      end
      sbit_cnt_q <= sbit_cnt_d;
      dbit_cnt_q <= dbit_cnt_d;
      log_vld_q  <= log_vld_d;
      log_syn_q  <= log_syn_d;
      log_dbit_q <= log_dbit_d;
    end
  end

  assign bus.enc_vld_out      = enc_vld_q;
  assign bus.enc_data_out     = enc_data_q;
  assign bus.enc_parity_out   = enc_par_q;
  assign bus.dec_in_rdy       = in_rdy;
  assign bus.dec_out_vld      = s2_vld_q;
  assign bus.dec_out_data     = s2_data_q;
  assign bus.dec_out_syndrome = s2_syn_q;
  assign bus.dec_out_sbit_err = s2_sbit_q;
  assign bus.dec_out_dbit_err = s2_dbit_q;
  assign bus.sbit_cnt         = sbit_cnt_q;
  assign bus.dbit_cnt         = dbit_cnt_q;
  assign bus.log_vld          = log_vld_q;
  assign bus.log_syndrome     = log_syn_q;
  assign bus.log_dbit         = log_dbit_q;
endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Scoreboard bench for ecc_secded_pipe: directed words are queued on issue and
// checked by a negedge monitor; a CNT_WIDTH=2 twin shares the stimulus.
module tb_ecc_secded_pipe;
  localparam int unsigned DW = 44;
  localparam int unsigned PW = 7;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic          sbit;
    logic          dbit;
    logic          lat;
  } dec_item_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] par;
  } enc_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(16)) bus ();
  ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(2))  bus_s ();

  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
  );

  assign bus_s.enc_vld_in    = bus.enc_vld_in;
  assign bus_s.enc_data_in   = bus.enc_data_in;
  assign bus_s.dec_in_vld    = bus.dec_in_vld;
  assign bus_s.dec_in_data   = bus.dec_in_data;
  assign bus_s.dec_in_parity = bus.dec_in_parity;
  assign bus_s.dec_in_bypass = bus.dec_in_bypass;
  assign bus_s.dec_out_rdy   = bus.dec_out_rdy;
  assign bus_s.cnt_clr       = bus.cnt_clr;
  assign bus_s.log_clr       = bus.log_clr;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
  bit mon_en = 1'b0;

  dec_item_t sb_q[$];
  enc_item_t enc_q[$];
  int        acc_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference encoder built straight from the Hamming-position definition.
  function automatic logic [PW-1:0] m_enc(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    int idx;
    p   = '0;
    idx = 0;
    for (int pos = 3; idx < int'(DW); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[idx]) begin
          p[5:0] = p[5:0] ^ pos[5:0];
          if (($countones(pos) % 2) == 0) p[6] = ~p[6];
        end
        idx++;
      end
    end
    return p;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    case (rdy_mode)
      1:       bus.dec_out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       bus.dec_out_rdy = 1'b0;
      default: bus.dec_out_rdy = 1'b1;
    endcase
  end

  // Monitor / scoreboard model state
  logic          exp_enc_vld = 1'b0;
  int            inflight = 0;
  logic [15:0]   m_sbit = '0, m_dbit = '0;
  logic [1:0]    m_sbit_s = '0, m_dbit_s = '0;
  logic          m_log_vld = 1'b0, m_log_dbit = 1'b0;
  logic [PW-1:0] m_log_syn = '0;
  logic          held = 1'b0;
  logic [DW-1:0] held_data;
  logic [PW-1:0] held_syn;
  logic          held_sb, held_db;

  always @(negedge clk) begin
    if (mon_en) begin
      dec_item_t it;
      enc_item_t ei;
      logic hs, inc_s, inc_d;
      hs    = bus.dec_out_vld && bus.dec_out_rdy;
      inc_s = 1'b0;
      inc_d = 1'b0;

      chk("enc_vld", bus.enc_vld_out, exp_enc_vld);
      if (bus.enc_vld_out && exp_enc_vld && enc_q.size() > 0) begin
        ei = enc_q.pop_front();
        chk("enc_data", bus.enc_data_out, ei.data);
        chk("enc_parity", bus.enc_parity_out, ei.par);
      end

      chk("in_rdy", bus.dec_in_rdy, !(inflight == 2 && bus.dec_out_vld && !bus.dec_out_rdy));
      chk("sbit_cnt", bus.sbit_cnt, m_sbit);
      chk("dbit_cnt", bus.dbit_cnt, m_dbit);
      chk("sbit_cnt_sat", bus_s.sbit_cnt, m_sbit_s);
      chk("dbit_cnt_sat", bus_s.dbit_cnt, m_dbit_s);
      chk("log_vld", bus.log_vld, m_log_vld);
      chk("log_syndrome", bus.log_syndrome, m_log_syn);
      chk("log_dbit", bus.log_dbit, m_log_dbit);

      if (held) begin
        chk("stall_vld", bus.dec_out_vld, 1);
        chk("stall_data", bus.dec_out_data, held_data);
        chk("stall_syn", bus.dec_out_syndrome, held_syn);
        chk("stall_flags", {bus.dec_out_sbit_err, bus.dec_out_dbit_err}, {held_sb, held_db});
      end
      held      = rst_n && bus.dec_out_vld && !bus.dec_out_rdy;
      held_data = bus.dec_out_data;
      held_syn  = bus.dec_out_syndrome;
      held_sb   = bus.dec_out_sbit_err;
      held_db   = bus.dec_out_dbit_err;

      if (rst_n) begin
        if (hs) begin
          if (sb_q.size() == 0 || acc_cyc_q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            int ac;
            it = sb_q.pop_front();
            ac = acc_cyc_q.pop_front();
            chk("out_data", bus.dec_out_data, it.data);
            chk("out_syndrome", bus.dec_out_syndrome, it.syn);
            chk("out_sbit", bus.dec_out_sbit_err, it.sbit);
            chk("out_dbit", bus.dec_out_dbit_err, it.dbit);
            if (it.lat) chk("latency", 64'(cyc - ac), 2);
            inc_s    = it.sbit;
            inc_d    = it.dbit;
            inflight = inflight - 1;
            if (bus.log_clr || !m_log_vld) begin
              if (it.sbit || it.dbit) begin
                m_log_vld  = 1'b1;
                m_log_syn  = it.syn;
                m_log_dbit = it.dbit;
              end
            end
          end
        end
        if (bus.log_clr && !(inc_s || inc_d)) m_log_vld = 1'b0;
        if (bus.cnt_clr) begin
          m_sbit = inc_s ? 16'd1 : 16'd0;  m_sbit_s = inc_s ? 2'd1 : 2'd0;
          m_dbit = inc_d ? 16'd1 : 16'd0;  m_dbit_s = inc_d ? 2'd1 : 2'd0;
        end else begin
          if (inc_s && m_sbit != 16'hFFFF) m_sbit = m_sbit + 16'd1;
          if (inc_s && m_sbit_s != 2'd3)   m_sbit_s = m_sbit_s + 2'd1;
          if (inc_d && m_dbit != 16'hFFFF) m_dbit = m_dbit + 16'd1;
          if (inc_d && m_dbit_s != 2'd3)   m_dbit_s = m_dbit_s + 2'd1;
        end
        if (bus.dec_in_vld && bus.dec_in_rdy) begin
          inflight = inflight + 1;
          acc_cyc_q.push_back(cyc);
        end
      end else begin
        sb_q.delete();
        enc_q.delete();
        acc_cyc_q.delete();
        inflight   = 0;
        m_sbit     = '0;  m_dbit   = '0;
        m_sbit_s   = '0;  m_dbit_s = '0;
        m_log_vld  = 1'b0;
        m_log_syn  = '0;
        m_log_dbit = 1'b0;
      end
      exp_enc_vld = rst_n && bus.enc_vld_in;
    end
  end

  task automatic enc(input logic [DW-1:0] d, input logic [PW-1:0] p);
    enc_item_t ei;
    ei.data = d;
    ei.par  = p;
    enc_q.push_back(ei);
    bus.enc_vld_in  = 1'b1;
    bus.enc_data_in = d;
    @(posedge clk); #1;
    bus.enc_vld_in = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp,
                      input logic [DW-1:0] ed, input logic [PW-1:0] es,
                      input logic esb, input logic edb, input logic lat);
    dec_item_t it;
    int n;
    it.data = ed;  it.syn = es;  it.sbit = esb;  it.dbit = edb;  it.lat = lat;
    sb_q.push_back(it);
    bus.dec_in_vld    = 1'b1;
    bus.dec_in_data   = d;
    bus.dec_in_parity = p;
    bus.dec_in_bypass = byp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dec_in_rdy && n < 100);
    chk("accept_timeout", bus.dec_in_rdy, 1);
    @(posedge clk); #1;
    bus.dec_in_vld    = 1'b0;
    bus.dec_in_bypass = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  localparam logic [DW-1:0] D = 44'h0A5_5A5A_5A5A;
  logic [PW-1:0] p_d;

  initial begin
    bus.enc_vld_in = 1'b0;  bus.enc_data_in = '0;
    bus.dec_in_vld = 1'b0;  bus.dec_in_data = '0;  bus.dec_in_parity = '0;
    bus.dec_in_bypass = 1'b0;  bus.cnt_clr = 1'b0;  bus.log_clr = 1'b0;
    bus.dec_out_rdy = 1'b1;
    p_d = m_enc(D);
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Encoder: hand-derived columns plus the reference word
    enc('0, 7'b0000000);
    enc(44'd1, 7'b1000011);
    enc(44'd8, 7'b0000111);
    enc(44'd9, 7'b1000100);
    enc(D, p_d);

    // Clean, single data flip, parity flip, double error
    send(D, p_d, 1'b0, D, 7'b0000000, 1'b0, 1'b0, 1'b1);
    drain();
    send(D ^ 44'd1, p_d, 1'b0, D, 7'b1000011, 1'b1, 1'b0, 1'b1);
    drain();
    chk("d0_sbit_cnt", bus.sbit_cnt, 1);
    chk("d0_log_vld", bus.log_vld, 1);
    chk("d0_log_syn", bus.log_syndrome, 7'b1000011);
    chk("d0_log_dbit", bus.log_dbit, 0);
    send(D, p_d ^ 7'b1000000, 1'b0, D, 7'b1000000, 1'b1, 1'b0, 1'b1);
    send(D ^ 44'd9, p_d, 1'b0, D ^ 44'd9, 7'b1000100, 1'b0, 1'b1, 1'b1);
    drain();
    chk("dbl_dbit_cnt", bus.dbit_cnt, 1);
    chk("dbl_log_kept", bus.log_syndrome, 7'b1000011);

    // Counter clear and log release coinciding with an sbit handshake
    send(D ^ 44'd8, p_d, 1'b0, D, 7'b0000111, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 bus.cnt_clr = 1'b1;
    @(posedge clk); #1 bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_sbit_cnt", bus.sbit_cnt, 1);
    drain();
    send(D ^ 44'd2, p_d, 1'b0, D, 7'b1000101, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 bus.log_clr = 1'b1;
    @(posedge clk); #1 bus.log_clr = 1'b0;
    @(negedge clk);
    chk("logclr_syn", bus.log_syndrome, 7'b1000101);
    drain();

    // Backpressure stream
    rdy_mode = 1;
    send(D,           p_d,           1'b0, D,           7'b0000000, 1'b0, 1'b0, 1'b0);
    send(D ^ 44'd1,   p_d,           1'b0, D,           7'b1000011, 1'b1, 1'b0, 1'b0);
    send(D ^ 44'd9,   p_d,           1'b0, D ^ 44'd9,   7'b1000100, 1'b0, 1'b1, 1'b0);
    send(D ^ 44'd2,   p_d,           1'b0, D,           7'b1000101, 1'b1, 1'b0, 1'b0);
    send(D,           p_d ^ 7'd1,    1'b0, D,           7'b0000001, 1'b1, 1'b0, 1'b0);
    send(D ^ 44'd8,   p_d,           1'b0, D,           7'b0000111, 1'b1, 1'b0, 1'b0);
    drain();
    rdy_mode = 0;
    drain();
    chk("sat_sbit_cnt", bus_s.sbit_cnt, 3);

    // Bypass: data passes uncorrected, syndrome still reported
    send(D ^ 44'd1, p_d, 1'b1, D ^ 44'd1, 7'b1000011, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset with both stages full and the log valid
    rdy_mode = 2;
    @(posedge clk); #1;
    send(D ^ 44'd1, p_d, 1'b0, D, 7'b1000011, 1'b1, 1'b0, 1'b0);
    send(D, p_d, 1'b0, D, 7'b0000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_rdy", bus.dec_in_rdy, 0);
    chk("full_log_vld", bus.log_vld, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_vld", bus.dec_out_vld, 0);
    chk("rst_enc_vld", bus.enc_vld_out, 0);
    chk("rst_sbit_cnt", bus.sbit_cnt, 0);
    chk("rst_dbit_cnt", bus.dbit_cnt, 0);
    chk("rst_log_vld", bus.log_vld, 0);
    chk("rst_log_syn", bus.log_syndrome, 0);
    chk("rst_in_rdy", bus.dec_in_rdy, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("no_leftover", 64'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SECDED (Hsiao-style, odd-weight column) encoder/decoder for FIFO and RAM protection in the sync_aggr datapath.
- Generalises the fixed 44/7 combinational corrector:
  - data and parity widths are parameters;
  - the decode path is a 2-stage valid/ready pipeline with backpressure;
  - a registered encode path is included;
  - saturating error counters and a first-error syndrome log are provided for scrub/status software.

Parameters:
- DATA_WIDTH, 44: protected data bits. Legal only if 2^(PARITY_WIDTH-1) - PARITY_WIDTH >= DATA_WIDTH.
- PARITY_WIDTH, 7: check bits, including the column-weight bit at the MSB.
- CNT_WIDTH, 16: width of each error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enc_vld_in  in  1  encode request
- enc_data_in  in  DATA_WIDTH  data to encode
- enc_vld_out  out  1  encode result valid
- enc_data_out  out  DATA_WIDTH  registered copy of the data
- enc_parity_out  out  PARITY_WIDTH  check bits
- dec_in_vld  in  1  decode input valid
- dec_in_rdy  out  1  decode input ready
- dec_in_data  in  DATA_WIDTH  stored data
- dec_in_parity  in  PARITY_WIDTH  stored check bits
- dec_in_bypass  in  1  pass data through uncorrected, flags forced 0
- dec_out_vld  out  1  decode result valid
- dec_out_rdy  in  1  downstream ready
- dec_out_data  out  DATA_WIDTH  corrected data
- dec_out_syndrome  out  PARITY_WIDTH  syndrome of this word
- dec_out_sbit_err  out  1  single-bit error, corrected
- dec_out_dbit_err  out  1  uncorrectable error
- sbit_cnt  out  CNT_WIDTH  accepted single-bit errors, saturating
- dbit_cnt  out  CNT_WIDTH  accepted uncorrectable errors, saturating
- cnt_clr  in  1  clear both counters
- log_vld  out  1  first-error log holds an entry
- log_syndrome  out  PARITY_WIDTH  syndrome of the first error
- log_dbit  out  1  1 = logged error was uncorrectable
- log_clr  in  1  release the log

Behaviour:

Interface rule (already decided): one clock `clk`; reset `rst_n` is synchronous and active-low.

Reset:
- All valid outputs, counters, log_vld, log_syndrome and log_dbit are 0.
- Data and flag registers are 0.
- dec_in_rdy is 1 from the first cycle after reset release.

Code construction:
- Data bit i maps to the i-th Hamming position >= 3 that is not a power of two (3, 5, 6, 7, 9, ...).
- For j < PARITY_WIDTH-1: p[j] = XOR of the data bits whose position has bit j set.
- p[PARITY_WIDTH-1] = XOR of the data bits whose position has even popcount, so every data column has odd weight.
- With DATA_WIDTH=44, PARITY_WIDTH=7, d[0] has column 1000011 and d[3] has column 0000111.

Encode:
- enc_vld_out, enc_data_out and enc_parity_out are registered 1 cycle after enc_vld_in.
- The encode path never stalls.

Decode pipeline:
- Stage 1 registers the data, bypass and syndrome (syndrome = dec_in_parity XOR encode(dec_in_data)).
- Stage 2 registers the correction result.
- Handshake:
  - s2 loads when !s2_vld or dec_out_rdy;
  - s1 advances when s2 loads;
  - dec_in_rdy = !s1_vld or s1 advances.
- Latency is 2 cycles with dec_out_rdy held high; throughput is 1 word per cycle.
- Outputs are held stable while dec_out_vld=1 and dec_out_rdy=0.
- No word may be dropped or duplicated.

Syndrome classification:
- Zero: no error.
- Equal to a data column: flip that data bit, sbit=1.
- One-hot (parity-bit error): data unchanged, sbit=1.
- Any other value: data unchanged, dbit=1.
- Bypass: data unchanged, both flags 0, syndrome still reported.

Counters:
- Increment on the output handshake (dec_out_vld and dec_out_rdy) when the matching flag is set.
- Saturate at all-ones.
- cnt_clr together with an increment in the same cycle gives a count of 1.

Error log:
- On the first handshake with sbit or dbit while log_vld=0, capture log_syndrome and log_dbit and set log_vld.
- Hold the entry until log_clr.
- log_clr together with a new error in the same cycle captures the new error.

Reset mid-operation:
- In-flight words are discarded and the counters and log are cleared.

Test Plan:
- Clean word: encode 44'h0A5_5A5A_5A5A, decode with that parity → dec_out after 2 cycles, data unchanged, syndrome 0, flags 0, counters unchanged.
- Single data flip: flip d[0] → syndrome 1000011, data corrected, sbit=1, sbit_cnt=1, log_vld=1, log_syndrome=1000011, log_dbit=0.
- Parity flip and double error:
  - flip parity bit 6 → syndrome 1000000, sbit=1, data unchanged;
  - flip d[0] and d[3] → syndrome 1000100, dbit=1, data uncorrected, dbit_cnt=1, log unchanged if already valid.
- Backpressure: stream 6 words with dec_out_rdy toggling 1,0,0,1,... → all 6 words out in order, none duplicated, in_rdy=0 while both stages are full and stalled; errors counted once per word.
- Bypass and saturation:
  - bypass word with a flipped bit → data passed through, flags 0, counters unchanged;
  - CNT_WIDTH=2 with 5 sbit words → sbit_cnt=3;
  - cnt_clr coincident with an sbit handshake → sbit_cnt=1.
- Reset: assert rst_n=0 for 1 cycle with both stages full and the log valid → next cycle all valids, counters and log are 0, and dec_in_rdy=1.
